// File: rtl/udp_audio_rx_unpack_if.sv
// Bus bundle for udp_audio_rx_unpack: UDP payload byte stream in, codec sample stream and status out.
interface udp_audio_rx_unpack_if #(
  parameter int DEPTH = 1024
);
  logic                       udp_rec_data_valid;
  logic [7:0]                 udp_rec_rdata;
  logic [15:0]                udp_rec_data_length;
  logic                       wav_rden;
  logic [15:0]                wav_out_data;
  logic [$clog2(DEPTH):0]     fifo_level;
  logic                       playing;
  logic [15:0]                drop_cnt;
  logic [15:0]                underrun_cnt;

  modport master (
    output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, wav_rden,
    input  wav_out_data, fifo_level, playing, drop_cnt, underrun_cnt
  );

  modport slave (
    input  udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, wav_rden,
    output wav_out_data, fifo_level, playing, drop_cnt, underrun_cnt
  );
endinterface

// File: rtl/udp_audio_rx_unpack.sv
// Unpacks little-endian 16-bit audio samples from UDP payload bytes into a FIFO with prefill-gated playback.
// Optional statistics counters are built when UDP_AUDIO_RX_STATS_EN is defined.
module udp_audio_rx_unpack #(
  parameter int DEPTH   = 1024,
  parameter int PREFILL = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  udp_audio_rx_unpack_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_LO, RX_HI, RX_DROP} rx_state_t;
  typedef enum logic       {PB_PREFILL, PB_PLAY}            pb_state_t;

  // ---------------------------------------------------------------- receive
  rx_state_t   rx_state, rx_next;
  logic [7:0]  lo_byte;
  logic [16:0] pkt_len;     // 17 bits so a length field of 0 can mean 65536
  logic [16:0] byte_cnt;
  logic        in_len;
  logic        wr_req;
  logic [15:0] wr_data;

  assign in_len  = byte_cnt < pkt_len;
  assign wr_data = {bus.udp_rec_rdata, lo_byte};

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    rx_next = rx_state;
    wr_req  = 1'b0;
    unique case (rx_state)
      RX_IDLE: if (bus.udp_rec_data_valid) rx_next = RX_LO;
      RX_LO: begin
        if (!bus.udp_rec_data_valid) rx_next = RX_IDLE;
        else if (in_len) begin
          rx_next = RX_HI;
          wr_req  = 1'b1;
        end else rx_next = RX_DROP;
      end
      RX_HI: begin
        if (!bus.udp_rec_data_valid) rx_next = RX_IDLE;
        else if (in_len)             rx_next = RX_LO;
        else                         rx_next = RX_DROP;
      end
      RX_DROP: if (!bus.udp_rec_data_valid) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      lo_byte  <= '0;
      pkt_len  <= '0;
      byte_cnt <= '0;
    end else begin
      rx_state <= rx_next;
      if (bus.udp_rec_data_valid) begin
        if (rx_state == RX_IDLE) begin
          pkt_len  <= (bus.udp_rec_data_length == 16'd0) ? 17'h1_0000
                                                         : {1'b0, bus.udp_rec_data_length};
          byte_cnt <= 17'd1;
          lo_byte  <= bus.udp_rec_rdata;
        end else if (rx_state != RX_DROP && in_len) begin
          byte_cnt <= byte_cnt + 17'd1;
          if (rx_state == RX_HI) lo_byte <= bus.udp_rec_rdata;
        end
      end
    end
  end

  // ------------------------------------------------------------ FIFO + play
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [15:0]   out_q;
  pb_state_t     pb_state, pb_next;
  logic          full, empty, push, pop, underrun;

  assign full  = level == LW'(DEPTH);
  assign empty = level == '0;
  // Fullness uses the registered level: a write into a full FIFO is dropped even if a pop coincides.
  assign push  = wr_req && !full;

  always_comb begin
    pb_next  = pb_state;
    pop      = 1'b0;
    underrun = 1'b0;
    unique case (pb_state)
      PB_PREFILL: if (level >= LW'(PREFILL)) pb_next = PB_PLAY;
      PB_PLAY: begin
        if (bus.wav_rden) begin
          if (empty) begin
            underrun = 1'b1;
            pb_next  = PB_PREFILL;
          end else pop = 1'b1;
        end
      end
      default: pb_next = PB_PREFILL;
    endcase
  end

  // NOTE: sample storage is deliberately not reset; only pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      out_q    <= '0;
      pb_state <= PB_PREFILL;
    end else begin
      pb_state <= pb_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A request that does not pop is either in PREFILL or an underrun; both output silence.
      if (pop)               out_q <= mem[rd_ptr];
      else if (bus.wav_rden) out_q <= '0;
    end
  end

  assign bus.wav_out_data = out_q;
  assign bus.fifo_level   = level;
  assign bus.playing      = pb_state == PB_PLAY;

  // ------------------------------------------------------------- statistics
`ifdef UDP_AUDIO_RX_STATS_EN
  logic [15:0] drop_q, under_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q  <= '0;
      under_q <= '0;
    end else begin
      if (wr_req && full && drop_q != 16'hFFFF) drop_q  <= drop_q + 16'd1;
      if (underrun && under_q != 16'hFFFF)      under_q <= under_q + 16'd1;
    end
  end

  assign bus.drop_cnt     = drop_q;
  assign bus.underrun_cnt = under_q;
`else
  assign bus.drop_cnt     = 16'h0000;
  assign bus.underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_udp_audio_rx_unpack.sv
// Self-checking bench for udp_audio_rx_unpack: directed scenarios plus randomized packets
// checked every cycle against a queue-based reference model.
module tb_udp_audio_rx_unpack;
  localparam int DEPTH   = 16;
  localparam int PREFILL = 4;
`ifdef UDP_AUDIO_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  udp_audio_rx_unpack_if #(.DEPTH(DEPTH)) bus ();

  udp_audio_rx_unpack #(.DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a sample queue plus play flag, output word and counters.
  logic [15:0] q[$];
  bit          m_play;
  logic [15:0] m_out;
  int          m_drop, m_under;
  bit          in_run;
  int          k, lf;
  logic [7:0]  prev_b;
  logic [7:0]  pkt[$];

  task automatic model_reset();
    q.delete();
    m_play  = 0;
    m_out   = 16'h0;
    m_drop  = 0;
    m_under = 0;
    in_run  = 0;
    k       = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_out"},   32'(bus.wav_out_data), 32'(m_out));
    check({tag, "_level"}, 32'(bus.fifo_level),   32'(q.size()));
    check({tag, "_play"},  32'(bus.playing),      32'(m_play));
    check({tag, "_drop"},  32'(bus.drop_cnt),     STATS ? 32'(m_drop)  : 32'd0);
    check({tag, "_under"}, 32'(bus.underrun_cnt), STATS ? 32'(m_under) : 32'd0);
  endtask

  // Drive one cycle, advance the model across the clock edge, then compare.
  task automatic drive_cycle(input logic v, input logic [7:0] b, input logic [15:0] len,
                             input logic rd);
    int          lvl;
    bit          wr, nplay;
    logic [15:0] ws;
    bus.udp_rec_data_valid  = v;
    bus.udp_rec_rdata       = b;
    bus.udp_rec_data_length = len;
    bus.wav_rden            = rd;
    @(posedge clk);
    lvl = q.size();
    wr  = 0;
    ws  = 16'h0;
    if (v) begin
      if (!in_run) begin
        in_run = 1;
        k      = 0;
        lf     = (len == 16'd0) ? 65536 : int'(len);
      end
      if (k < lf && (k % 2) == 1) begin
        wr = 1;
        ws = {b, prev_b};
      end
      prev_b = b;
      k++;
    end else in_run = 0;
    nplay = m_play;
    if (rd) begin
      if (m_play && lvl > 0) m_out = q.pop_front();
      else begin
        m_out = 16'h0;
        if (m_play) begin
          if (m_under < 16'hFFFF) m_under++;
          nplay = 0;
        end
      end
    end
    if (wr) begin
      if (lvl == DEPTH) begin
        if (m_drop < 16'hFFFF) m_drop++;
      end else q.push_back(ws);
    end
    if (!m_play && lvl >= PREFILL) nplay = 1;
    m_play = nplay;
    #1;
    check_all("cyc");
  endtask

  task automatic send_pkt(input logic [15:0] len, input int rd_pct);
    foreach (pkt[i])
      drive_cycle(1'b1, pkt[i], (i == 0) ? len : 16'($urandom),
                  $urandom_range(99) < rd_pct);
    drive_cycle(1'b0, 8'($urandom), 16'($urandom), 1'b0);
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] exp);
    drive_cycle(1'b0, 8'h00, 16'h0, 1'b1);
    check(tag, 32'(bus.wav_out_data), 32'(exp));
  endtask

  initial begin
    bus.udp_rec_data_valid  = 1'b0;
    bus.udp_rec_rdata       = 8'h0;
    bus.udp_rec_data_length = 16'h0;
    bus.wav_rden            = 1'b0;
    prev_b                  = 8'h0;
    lf                      = 0;
    model_reset();
    rst_n = 1'b0;
    #12;
    check("rst_out",   32'(bus.wav_out_data), 32'd0);
    check("rst_level", 32'(bus.fifo_level),   32'd0);
    check("rst_play",  32'(bus.playing),      32'd0);
    check("rst_drop",  32'(bus.drop_cnt),     32'd0);
    check("rst_under", 32'(bus.underrun_cnt), 32'd0);
    #1 rst_n = 1'b1;

    // Basic fill to PREFILL and ordered playback with one-cycle latency.
    pkt = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
    send_pkt(16'd8, 0);
    check("basic_level", 32'(bus.fifo_level), 32'd4);
    check("basic_play",  32'(bus.playing),    32'd1);
    pop_expect("basic_pop1", 16'h0001);
    pop_expect("basic_pop2", 16'h0002);
    pop_expect("basic_pop3", 16'h0003);
    pop_expect("basic_pop4", 16'h0004);

    // Underrun on an empty FIFO while playing.
    drive_cycle(1'b0, 8'h00, 16'h0, 1'b1);
    check("urun_out",   32'(bus.wav_out_data), 32'd0);
    check("urun_play",  32'(bus.playing),      32'd0);
    check("urun_cnt",   32'(bus.underrun_cnt), STATS ? 32'd1 : 32'd0);

    // Odd length: trailing low byte discarded.
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_pkt(16'd5, 0);
    check("odd_level", 32'(bus.fifo_level), 32'd2);

    // Run longer than the length field: extra bytes discarded; refill restarts playback.
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    send_pkt(16'd4, 0);
    check("trunc_level", 32'(bus.fifo_level), 32'd4);
    check("refill_play", 32'(bus.playing),    32'd1);
    pop_expect("odd_pop1",   16'h2211);
    pop_expect("odd_pop2",   16'h4433);
    pop_expect("trunc_pop1", 16'hBBAA);
    pop_expect("trunc_pop2", 16'hDDCC);

    // Overfill: 18 samples into a 16-deep FIFO.
    pkt.delete();
    for (int i = 0; i < 18; i++) begin
      pkt.push_back(8'(i));
      pkt.push_back(8'hA0);
    end
    send_pkt(16'd36, 0);
    check("full_level", 32'(bus.fifo_level), 32'd16);
    check("full_drop",  32'(bus.drop_cnt),   STATS ? 32'd2 : 32'd0);

    // Drain to 3, then pop on the same cycle as a high-byte write.
    for (int i = 0; i < 13; i++) drive_cycle(1'b0, 8'h00, 16'h0, 1'b1);
    check("drain_out",   32'(bus.wav_out_data), 32'hA00C);
    check("drain_level", 32'(bus.fifo_level),   32'd3);
    drive_cycle(1'b1, 8'h34, 16'd2, 1'b0);
    drive_cycle(1'b1, 8'h12, 16'h0, 1'b1);
    check("simul_level", 32'(bus.fifo_level),   32'd3);
    check("simul_out",   32'(bus.wav_out_data), 32'hA00D);
    drive_cycle(1'b0, 8'h00, 16'h0, 1'b0);

    // Asynchronous reset in the middle of a packet; the rest becomes a new packet.
    drive_cycle(1'b1, 8'h01, 16'd6, 1'b0);
    drive_cycle(1'b1, 8'h02, 16'd6, 1'b0);
    drive_cycle(1'b1, 8'h03, 16'd6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_out",   32'(bus.wav_out_data), 32'd0);
    check("arst_level", 32'(bus.fifo_level),   32'd0);
    check("arst_play",  32'(bus.playing),      32'd0);
    check("arst_drop",  32'(bus.drop_cnt),     32'd0);
    check("arst_under", 32'(bus.underrun_cnt), 32'd0);
    #2 rst_n = 1'b1;
    drive_cycle(1'b1, 8'h78, 16'd4, 1'b0);
    drive_cycle(1'b1, 8'h56, 16'd4, 1'b0);
    drive_cycle(1'b1, 8'h9A, 16'd4, 1'b0);
    drive_cycle(1'b1, 8'hBC, 16'd4, 1'b0);
    drive_cycle(1'b0, 8'h00, 16'h0, 1'b0);
    check("arst_newpkt_level", 32'(bus.fifo_level), 32'd2);

    // Randomized packets, lengths, gaps and sample requests.
    for (int p = 0; p < 150; p++) begin
      int          n, sel, rd_pct, gap;
      logic [15:0] len;
      n      = $urandom_range(1, 40);
      sel    = $urandom_range(3);
      rd_pct = $urandom_range(10, 70);
      case (sel)
        0:       len = 16'd0;
        1:       len = 16'(n);
        2:       len = 16'($urandom_range(1, 40));
        default: len = 16'((n > 1) ? n - 1 : 1);
      endcase
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      send_pkt(len, rd_pct);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        drive_cycle(1'b0, 8'($urandom), 16'($urandom), $urandom_range(99) < rd_pct);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
